// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//
// Instruction-memory read bus between the fetch controller (master) and the
// instruction memory (slave).
//
// Handshake: the master raises mem_req with mem_addr. It holds both stable
// until the slave returns mem_ack. mem_rdata is valid only in a cycle with
// mem_ack=1. The transfer completes on the rising edge where mem_req and
// mem_ack are both 1. The master drops mem_req in the next cycle. An ack seen
// while mem_req=0 carries no meaning and the master ignores it.
//
// Signals:
//   mem_req    master -> slave  read request
//   mem_addr   master -> slave  32-bit byte address (word aligned)
//   mem_ack    slave  -> master read data valid / request accepted
//   mem_rdata  slave  -> master 32-bit instruction word
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch/branch sequencer for a simple in-order core. For each instruction the
// controller does the following, in order:
//   1. It samples the program counter from the PC block.
//   2. It issues one read on the instruction-memory bus.
//   3. It hands the word to the datapath and waits for exec_done.
//   4. It tells the PC block either to step sequentially (pc_advance) or to
//      redirect by a signed offset (branch / branch_offset).
//
// The FINISH_INSTR word ends the run. The controller then parks in a terminal
// state with finish_flag set. A misaligned PC, or a memory that never
// acknowledges, parks it in a terminal error state instead. Both terminal
// states are left only through reset.
//
// Parameters:
//   FINISH_INSTR  instruction word that ends execution
//   ACK_TIMEOUT   number of FETCH cycles allowed without mem_ack
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   pc_in          current program counter (signed)
//   mem            instruction memory bus (master side)
//   instr_out      fetched instruction, held through execution
//   instr_valid    instr_out is valid for the datapath (EXEC only)
//   exec_done      datapath consumed instr_out; compare flags valid
//   cmp_eq         rs1 == rs2
//   cmp_lt         signed rs1 < rs2
//   cmp_ltu        unsigned rs1 < rs2
//   pc_advance     one-cycle permit for sequential PC increment
//   branch         one-cycle PC redirect pulse
//   branch_offset  sign-extended byte offset for the redirect
//   finish_flag    sticky end-of-program indication
//   fetch_err      sticky error (ack timeout or misaligned pc_in)
//   fsm_state      current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] FINISH_INSTR = 32'h00000073,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] pc_in,
  fetch_ctrl_if.master       mem,
  output logic        [31:0] instr_out,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               cmp_eq,
  input  logic               cmp_lt,
  input  logic               cmp_ltu,
  output logic               pc_advance,
  output logic               branch,
  output logic signed [31:0] branch_offset,
  output logic               finish_flag,
  output logic               fetch_err,
  output logic        [2:0]  fsm_state
);

  // The counter must be able to hold ACK_TIMEOUT-1 (the last FETCH cycle).
  localparam int                 CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_REDIRECT = 3'd3,
    S_ADVANCE  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ack_cnt;
  logic             req_q;
  logic [31:0]      addr_q;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign fsm_state    = state;

  // -------------------------------------------------------------------------
  // Branch decode. It works on the registered instruction, which is stable
  // for the whole of EXEC, so the taken decision and the offset are ready
  // when exec_done arrives.
  // -------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] b_offset;
  logic [31:0] j_offset;
  logic        taken;
  logic [31:0] target_offset;

  assign opcode = instr_out[6:0];
  assign funct3 = instr_out[14:12];

  // B-type immediate: 13 bits, bit 0 implied zero.
  assign b_offset = {{19{instr_out[31]}}, instr_out[31], instr_out[7],
                     instr_out[30:25], instr_out[11:8], 1'b0};

  // J-type immediate: 21 bits, bit 0 implied zero.
  assign j_offset = {{11{instr_out[31]}}, instr_out[31], instr_out[19:12],
                     instr_out[20], instr_out[30:21], 1'b0};

  always_comb begin
    taken         = 1'b0;
    target_offset = b_offset;
    if (opcode == OPC_JAL) begin
      taken         = 1'b1;
      target_offset = j_offset;
    end else if (opcode == OPC_BRANCH) begin
      case (funct3)
        3'b000:  taken = cmp_eq;
        3'b001:  taken = ~cmp_eq;
        3'b100:  taken = cmp_lt;
        3'b101:  taken = ~cmp_lt;
        3'b110:  taken = cmp_ltu;
        3'b111:  taken = ~cmp_ltu;
        // 010/011 are unused branch encodings: fall through as not taken.
        default: taken = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Main FSM. All outputs are registered and are set on the edge that enters
  // the state that owns them. As a result each output is high exactly while
  // the FSM sits in that state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ack_cnt       <= '0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      instr_out     <= '0;
      instr_valid   <= 1'b0;
      pc_advance    <= 1'b0;
      branch        <= 1'b0;
      branch_offset <= '0;
      finish_flag   <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_in[1:0] != 2'b00) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            addr_q  <= $unsigned(pc_in);
            ack_cnt <= '0;
            req_q   <= 1'b1;
            state   <= S_FETCH;
          end
        end

        S_FETCH: begin
          // An ack in the last allowed cycle still completes the fetch, so
          // the ack is tested before the timeout.
          if (mem.mem_ack) begin
            req_q     <= 1'b0;
            instr_out <= mem.mem_rdata;
            if (mem.mem_rdata == FINISH_INSTR) begin
              finish_flag <= 1'b1;
              state       <= S_DONE;
            end else begin
              instr_valid <= 1'b1;
              state       <= S_EXEC;
            end
          end else if (ack_cnt == CNT_LAST) begin
            req_q     <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        S_EXEC: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (taken) begin
              branch        <= 1'b1;
              branch_offset <= target_offset;
              state         <= S_REDIRECT;
            end else begin
              pc_advance <= 1'b1;
              state      <= S_ADVANCE;
            end
          end
        end

        S_REDIRECT: begin
          branch <= 1'b0;
          state  <= S_IDLE;
        end

        S_ADVANCE: begin
          pc_advance <= 1'b0;
          state      <= S_IDLE;
        end

        S_DONE: begin
          req_q <= 1'b0;
        end

        S_ERR: begin
          req_q <= 1'b0;
        end

        // The unused encoding is treated as a fault and parks the FSM.
        default: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
          pc_advance  <= 1'b0;
          branch      <= 1'b0;
          fetch_err   <= 1'b1;
          state       <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: FINISH_INSTR, default 32'h00000073, instruction word that ends execution; ACK_TIMEOUT, default 16, maximum FETCH cycles to wait for mem_ack.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 pc_in  input  32  current program counter from the PC block, signed.
REQ-005 mem_req, mem_addr  output  1, 32  instruction memory read request and word address.
REQ-006 mem_ack, mem_rdata  input  1, 32  memory acknowledge and read data; rdata valid only when ack=1.
REQ-007 instr_out, instr_valid  output  32, 1  fetched instruction to the datapath and its valid qualifier.
REQ-008 exec_done  input  1  datapath has consumed instr_out; compare flags are valid this cycle.
REQ-009 cmp_eq, cmp_lt, cmp_ltu  input  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
REQ-010 pc_advance  output  1  one-cycle permit for sequential PC increment.
REQ-011 branch, branch_offset  output  1, 32 signed  one-cycle redirect pulse and sign-extended byte offset to add to PC.
REQ-012 finish_flag  output  1  sticky end-of-program indication to the PC block.
REQ-013 fetch_err  output  1  sticky error: ack timeout or misaligned pc_in.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, EXEC, REDIRECT, ADVANCE, DONE and ERR.
REQ-015 IDLE: if pc_in[1:0]!=0 -> ERR; else latch mem_addr=pc_in, clear the timeout counter, and go to FETCH on the next edge.
REQ-016 FETCH: mem_req=1 and mem_addr held stable; on mem_ack, latch mem_rdata into instr_out and leave FETCH on the same edge.
REQ-017 On mem_ack, if mem_rdata==FINISH_INSTR -> DONE; otherwise -> EXEC.
REQ-018 FETCH timeout: on the ACK_TIMEOUT-th cycle without ack -> ERR; if mem_ack arrives in that same cycle, the ack wins.
REQ-019 EXEC: instr_valid=1, and instr_out is held until exec_done=1.
REQ-020 At exec_done, the taken decision SHALL be: opcode 7'b1100011 with funct3 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; opcode 7'b1101111 (JAL) is always taken.
REQ-021 B-type funct3 010/011 SHALL be treated as not taken, with no error raised.
REQ-022 At exec_done: taken -> REDIRECT; not taken -> ADVANCE.
REQ-023 exec_done outside EXEC SHALL be ignored.
REQ-024 REDIRECT: branch=1 for exactly one cycle; pc_advance=0; then -> IDLE.
REQ-025 B-type branch_offset SHALL be sign-extend of {i[31],i[7],i[30:25],i[11:8],1'b0}, a 13-bit value.
REQ-026 JAL branch_offset SHALL be sign-extend of {i[31],i[19:12],i[20],i[30:21],1'b0}, a 21-bit value.
REQ-027 branch_offset SHALL be registered and remain stable until the next REDIRECT.
REQ-028 ADVANCE: pc_advance=1 for exactly one cycle; branch=0; then -> IDLE.
REQ-029 branch and pc_advance SHALL never both be 1 in the same cycle.
REQ-030 DONE: finish_flag=1; the state is terminal and all requests stop until reset.
REQ-031 ERR: fetch_err=1 and mem_req=0; the state is terminal until reset.
REQ-032 mem_req SHALL be 1 only in FETCH.
REQ-033 instr_valid SHALL be 1 only in EXEC.

Reset
REQ-034 While reset=1, the FSM SHALL be in IDLE and the block SHALL NOT start a fetch.
REQ-035 Reset SHALL clear mem_req, instr_valid, pc_advance, branch, finish_flag and fetch_err to 0.
REQ-036 Reset SHALL clear mem_addr, instr_out, branch_offset and the timeout counter to 0.
REQ-037 Reset asserted mid-FETCH or mid-EXEC SHALL abort immediately; a late mem_ack after release SHALL be ignored unless the FSM is in FETCH.
REQ-038 After reset release, the first fetch SHALL begin one cycle after IDLE samples an aligned pc_in.

Verification
REQ-039 pc_in=0x10, memory acks after 2 cycles with 0x00000013 (addi), exec_done 1 cycle later -> mem_addr=0x10, instr_valid for 1 cycle, pc_advance pulse, branch=0.
REQ-040 Fetch 0xFE000EE3 (beq x0,x0,-4), cmp_eq=1 at exec_done -> branch=1 for one cycle, branch_offset=0xFFFFFFFC, no pc_advance pulse.
REQ-041 Same beq with cmp_eq=0 -> pc_advance pulse, branch=0; then JAL 0x0080006F -> branch pulse with offset=0x00000008.
REQ-042 Fetch 0x00000073 -> finish_flag=1 on the ack edge, no instr_valid; mem_req stays 0 for the following 20 cycles.
REQ-043 With no mem_ack, ERR is entered after 16 cycles: fetch_err=1, mem_req=0; with ack on exactly cycle 16 -> normal EXEC, no error.
REQ-044 Reset pulsed during EXEC -> all outputs 0 asynchronously; pc_in=0x6 after release -> fetch_err=1 with no mem_req.
